load_writeback: RTL
===================

# load_writeback

Multicycle load engine sitting between the data-memory port and the register file's write port (`rd`, `write_data`, `reg_write`). On a `start` pulse it registers the load's address, funct3 and destination, then:
- issues a word-aligned read with a valid/ready request handshake;
- waits for the response;
- extracts and sign- or zero-extends the addressed byte, halfword or word;
- drives a single-cycle register-file write.

It is the writing master of the register file's write port for all RV32I loads.

## Interface
- ADDR_W, 32, byte-address width of `addr` and `mem_req_addr`
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  load request; accepted only in IDLE
- addr  in  ADDR_W  effective byte address; sampled with `start`
- funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101; sampled with `start`
- rd_in  in  5  destination register; sampled with `start`
- busy  out  1  high in any state other than IDLE
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  `{addr[ADDR_W-1:2], 2'b00}`, registered
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  little-endian read word
- rd  out  5  register-file destination
- write_data  out  32  extended load result
- reg_write  out  1  register-file write strobe
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse: illegal funct3, or misaligned access (when checked)

## Operation
- States: IDLE, REQ, WAIT, WB.
- **IDLE**
  - `start=1` with a legal, aligned request: latch `addr`, `funct3`, `rd_in`, go to REQ.
  - `start=1` with an illegal funct3 (011, 110, 111) or a misaligned access: pulse `fault` the next cycle, stay IDLE, issue no memory request and no write.
- **REQ**: `mem_req_valid=1`; `mem_req_addr` stays stable. On `mem_req_valid & mem_req_ready`, go to WAIT. `mem_rsp_valid` is ignored in REQ.
- **WAIT**: on `mem_rsp_valid`, register the formatted result into `write_data` and go to WB.
- **WB**: `done=1` for one cycle; `reg_write=1` unless the latched `rd==0`; `rd` holds the latched destination. Next state is IDLE.
- Lane selection:
  - byte = `mem_rsp_data[8*a+7:8*a]`, with `a = addr[1:0]`;
  - halfword = `mem_rsp_data[16*h+15:16*h]`, with `h = addr[1]`.
- Extension: LB/LH sign-extend bit 7 / bit 15; LBU/LHU zero-fill; LW passes the word unchanged.
- `start` while `busy=1` is ignored and does not disturb the latched fields.
- `rd`, `write_data` and `mem_req_addr` hold their last values between operations. Only the strobes `reg_write`, `done`, `fault` and `mem_req_valid` return to 0.

## Timing
- Reset: state=IDLE; `busy`, `mem_req_valid`, `reg_write`, `done`, `fault` = 0; `rd`, `write_data`, `mem_req_addr` = 0.
- Reset asserted mid-operation aborts immediately. A memory response arriving after reset is ignored because IDLE does not sample `mem_rsp_valid`.
- Cycle numbering for a legal load, with `start` sampled at edge 0:
  - `mem_req_valid=1` from cycle 1.
  - With `mem_req_ready=1` at cycle 1 and `mem_rsp_valid=1` at cycle 2, `reg_write`/`done` are high in cycle 3.
  - Minimum start-to-write latency is therefore 3 cycles, plus any request stall and response wait cycles.
- A new `start` is accepted in the cycle after WB (back-to-back throughput of one load per 4 cycles minimum).
- `fault` is high in cycle 1 for a rejected request; `busy` stays 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `LOAD_WB_MISALIGN_CHECK_EN` defined:
  - LH/LHU with `addr[0]=1` is misaligned and raises `fault`;
  - LW/LBU-agnostic rule for words: LW with `addr[1:0]!=0` is misaligned and raises `fault`.
- Not defined:
  - no misalignment fault is ever raised;
  - LH/LHU ignore `addr[0]` and select lanes with `addr[1]`;
  - LW ignores `addr[1:0]`;
  - illegal-funct3 faults remain active.

## Test plan
- LB at addr 0x103, response 0x80FF_1234 -> cycle 3: `reg_write=1`, `rd=5`, `write_data=0xFFFF_FF80`, `done=1`.
- LHU at addr 0x102, response 0x8001_7FFF, `mem_req_ready` low for 2 cycles -> `mem_req_addr=0x100` held stable; write in cycle 5 with `write_data=0x0000_8001`.
- LW to rd=0, response 0xDEAD_BEEF -> `done=1`, `reg_write=0`; a `start` issued during WAIT is ignored.
- funct3=011 -> `fault=1` in cycle 1, no `mem_req_valid`, `busy` stays 0. LH at 0x101 with the macro defined -> `fault=1`; without it -> load completes reading lane 0.
- `rst` asserted in WAIT, response arrives 1 cycle after release -> all outputs 0, no `reg_write`; a following LBU at 0x0 with response 0x0000_00AB -> `write_data=0x0000_00AB`.

Source files
------------

// File: rtl/load_writeback.sv
// Multicycle RV32I load engine: word-aligned memory read, lane extraction/extension, one-cycle register-file write.
// Optional macro LOAD_WB_MISALIGN_CHECK_EN enables misaligned halfword/word faults.
module load_writeback #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd_in,
  output logic              busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic [4:0]        rd,
  output logic [31:0]       write_data,
  output logic              reg_write,
  output logic              done,
  output logic              fault
);

  // Handshake: a request transfers on any rising edge where mem_req_valid and
  // mem_req_ready are both high; valid stays up and mem_req_addr stays stable until then.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_t      state, state_next;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        legal, misaligned, accept, reject;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] formatted;

  always_comb begin
    legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
            (funct3 == F3_LBU) || (funct3 == F3_LHU);
`ifdef LOAD_WB_MISALIGN_CHECK_EN
    misaligned = ((funct3 == F3_LH || funct3 == F3_LHU) && addr[0]) ||
                 ((funct3 == F3_LW) && (addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    accept = (state == IDLE) && start && legal && !misaligned;
    reject = (state == IDLE) && start && !(legal && !misaligned);
  end

  // Halfword lane uses only addr[1], so an unchecked odd halfword reads its aligned lane.
  always_comb begin
    byte_v = mem_rsp_data[{lane_q, 3'b000} +: 8];
    half_v = mem_rsp_data[{lane_q[1], 4'b0000} +: 16];
    case (f3_q)
      F3_LB:   formatted = {{24{byte_v[7]}}, byte_v};
      F3_LH:   formatted = {{16{half_v[15]}}, half_v};
      F3_LBU:  formatted = {24'h000000, byte_v};
      F3_LHU:  formatted = {16'h0000, half_v};
      default: formatted = mem_rsp_data;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ;
      REQ:     if (mem_req_ready) state_next = WAIT;
      WAIT:    if (mem_rsp_valid) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      f3_q          <= 3'b000;
      lane_q        <= 2'b00;
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      rd            <= 5'd0;
      write_data    <= 32'd0;
      reg_write     <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_next;
      busy          <= (state_next != IDLE);
      mem_req_valid <= (state_next == REQ);
      done          <= (state_next == WB);
      reg_write     <= (state_next == WB) && (rd != 5'd0);
      fault         <= reject;
      if (accept) begin
        f3_q         <= funct3;
        lane_q       <= addr[1:0];
        rd           <= rd_in;
        mem_req_addr <= {addr[ADDR_W-1:2], 2'b00};
      end
      if (state == WAIT && mem_rsp_valid) write_data <= formatted;
    end
  end

endmodule
